// File: rtl/sensor_temp_avg.sv
// sensor_temp_avg: latches four sensor readings plus an enable mask on start,
// sums the enabled readings one per cycle, then divides by the enabled count
// with a 16-iteration restoring divider.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-high reset
//   start                      acquisition request, sampled only while idle
//   sensor1..sensor4           unsigned readings (mask bits 0..3)
//   sensor_en                  per-sensor include mask
//   t_act                      floor(sum/count), held between acquisitions
//   drop_en                    last acquisition had at least one enabled sensor
//   busy                       acquisition in progress
//   done                       one-cycle pulse on the cycle t_act/drop_en update
module sensor_temp_avg #(
   parameter int unsigned SENS_W = 8,
   parameter int unsigned OUT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [SENS_W-1:0] sensor1,
   input  logic [SENS_W-1:0] sensor2,
   input  logic [SENS_W-1:0] sensor3,
   input  logic [SENS_W-1:0] sensor4,
   input  logic [3:0]        sensor_en,
   output logic [OUT_W-1:0]  t_act,
   output logic              drop_en,
   output logic              busy,
   output logic              done
);

   localparam int unsigned SUM_W  = SENS_W + 2;
   localparam int unsigned CNT_W  = 3;
   localparam int unsigned DVD_W  = 16;
   localparam int unsigned REM_W  = 3;
   localparam int unsigned STEP_W = 4;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SUM,
      S_DIV,
      S_DONE
   } state_t;

   state_t                   state_q, state_d;
   logic [3:0][SENS_W-1:0]   sens_q, sens_d;
   logic [3:0]               mask_q, mask_d;
   logic [SUM_W-1:0]         sum_q, sum_d;
   logic [CNT_W-1:0]         count_q, count_d;
   logic [STEP_W-1:0]        step_q, step_d;
   logic [DVD_W-1:0]         dvd_q, dvd_d;
   logic [DVD_W-1:0]         quot_q, quot_d;
   logic [REM_W-1:0]         rem_q, rem_d;
   logic [OUT_W-1:0]         t_act_q, t_act_d;
   logic                     drop_en_q, drop_en_d;
   logic                     busy_q, busy_d;
   logic                     done_q, done_d;
   logic [REM_W-1:0]         trial;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sens_q    <= '0;
         mask_q    <= '0;
         sum_q     <= '0;
         count_q   <= '0;
         step_q    <= '0;
         dvd_q     <= '0;
         quot_q    <= '0;
         rem_q     <= '0;
         t_act_q   <= '0;
         drop_en_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         sens_q    <= sens_d;
         mask_q    <= mask_d;
         sum_q     <= sum_d;
         count_q   <= count_d;
         step_q    <= step_d;
         dvd_q     <= dvd_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         t_act_q   <= t_act_d;
         drop_en_q <= drop_en_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state, accumulate and divide
   always_comb begin
      state_d   = state_q;
      sens_d    = sens_q;
      mask_d    = mask_q;
      sum_d     = sum_q;
      count_d   = count_q;
      step_d    = step_q;
      dvd_d     = dvd_q;
      quot_d    = quot_q;
      rem_d     = rem_q;
      t_act_d   = t_act_q;
      drop_en_d = drop_en_q;
      trial     = '0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               sens_d  = {sensor4, sensor3, sensor2, sensor1};
               mask_d  = sensor_en;
               sum_d   = '0;
               count_d = '0;
               step_d  = '0;
               state_d = S_SUM;
            end
         end
         S_SUM: begin
            // Steps 0..3 accumulate one sensor each; step 4 decides on the final count
            if (step_q < STEP_W'(4)) begin
               if (mask_q[step_q[1:0]]) begin
                  sum_d   = sum_q + SUM_W'(sens_q[step_q[1:0]]);
                  count_d = count_q + CNT_W'(1);
               end
               step_d = step_q + STEP_W'(1);
            end else if (count_q == '0) begin
               t_act_d   = '0;
               drop_en_d = 1'b0;
               state_d   = S_DONE;
            end else begin
               dvd_d   = DVD_W'(sum_q);
               quot_d  = '0;
               rem_d   = '0;
               step_d  = '0;
               state_d = S_DIV;
            end
         end
         S_DIV: begin
            // Remainder stays below count (<=4), so a 3-bit trial value is enough
            trial = {rem_q[REM_W-2:0], dvd_q[DVD_W-1]};
            if (trial >= REM_W'(count_q)) begin
               rem_d  = trial - REM_W'(count_q);
               quot_d = {quot_q[DVD_W-2:0], 1'b1};
            end else begin
               rem_d  = trial;
               quot_d = {quot_q[DVD_W-2:0], 1'b0};
            end
            dvd_d  = {dvd_q[DVD_W-2:0], 1'b0};
            step_d = step_q + STEP_W'(1);
            if (step_q == STEP_W'(15)) begin
               t_act_d   = OUT_W'(quot_d);
               drop_en_d = 1'b1;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // busy covers the working cycles after acceptance and drops as done rises
      done_d = (state_d == S_DONE);
      busy_d = ((state_q == S_SUM) || (state_q == S_DIV)) && (state_d != S_DONE);
   end

   assign t_act   = t_act_q;
   assign drop_en = drop_en_q;
   assign busy    = busy_q;
   assign done    = done_q;

endmodule

// File: tb/tb_sensor_temp_avg.sv
// Testbench for sensor_temp_avg: directed scenarios plus randomized acquisitions
// compared against an arithmetic reference average.
module tb_sensor_temp_avg;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  sensor1, sensor2, sensor3, sensor4;
   logic [3:0]  sensor_en;
   logic [15:0] t_act;
   logic        drop_en;
   logic        busy;
   logic        done;

   int checks = 0;
   int errors = 0;

   sensor_temp_avg #(.SENS_W(8), .OUT_W(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .sensor1   (sensor1),
      .sensor2   (sensor2),
      .sensor3   (sensor3),
      .sensor4   (sensor4),
      .sensor_en (sensor_en),
      .t_act     (t_act),
      .drop_en   (drop_en),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Reference: truncated mean of the enabled readings, 0 when none enabled
   function automatic int ref_avg(input int s1, input int s2, input int s3, input int s4,
                                  input logic [3:0] m);
      int vals[4];
      int sum;
      int cnt;
      vals[0] = s1; vals[1] = s2; vals[2] = s3; vals[3] = s4;
      sum = 0;
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         if (m[i]) begin
            sum += vals[i];
            cnt++;
         end
      end
      return (cnt == 0) ? 0 : sum / cnt;
   endfunction

   // Drive one acquisition and observe it for 30 cycles after acceptance.
   // lat is the cycle index (0 = cycle after the accepting edge) of the first done.
   task automatic run_acq(input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3,
                          input logic [7:0] s4, input logic [3:0] m, input bit disturb,
                          output int lat, output int busy_n, output int done_n,
                          output logic [15:0] t_done, output logic d_done,
                          output int unstable);
      logic [15:0] t_prev;
      logic        d_prev;
      sensor1 = s1; sensor2 = s2; sensor3 = s3; sensor4 = s4;
      sensor_en = m;
      start = 1'b1;
      t_prev = t_act;
      d_prev = drop_en;
      @(negedge clk);
      start = 1'b0;
      lat = -1; busy_n = 0; done_n = 0; unstable = 0;
      t_done = '0; d_done = 1'b0;
      for (int c = 0; c < 30; c++) begin
         if (busy) busy_n++;
         if (done) begin
            done_n++;
            if (lat < 0) begin
               lat = c;
               t_done = t_act;
               d_done = drop_en;
            end
         end else if (lat < 0) begin
            if (t_act !== t_prev || drop_en !== d_prev) unstable++;
         end else begin
            if (t_act !== t_done || drop_en !== d_done) unstable++;
         end
         if (disturb) begin
            if (c == 2) begin
               sensor1 = 8'($urandom_range(0, 255));
               sensor2 = 8'($urandom_range(0, 255));
               sensor3 = 8'($urandom_range(0, 255));
               sensor4 = 8'($urandom_range(0, 255));
               sensor_en = 4'($urandom_range(0, 15));
            end
            start = (c == 3 || c == 10);
         end
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b0;
      sensor1 = '0; sensor2 = '0; sensor3 = '0; sensor4 = '0;
      sensor_en = '0;
      repeat (3) @(negedge clk);
      checks++;
      if (t_act !== 16'd0 || drop_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: t_act=%0d drop_en=%b busy=%b done=%b, required 0 0 0 0",
                  t_act, drop_en, busy, done);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      int lat, bn, dn, un;
      logic [15:0] t;
      logic d;
      run_acq(8'd20, 8'd22, 8'd24, 8'd26, 4'b1111, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (lat !== 21) begin
         errors++; $display("FAIL basic_latency: got %0d required 21", lat);
      end
      checks++;
      if (t !== 16'd23 || d !== 1'b1) begin
         errors++; $display("FAIL basic_result: t_act=%0d drop_en=%b required 23 1", t, d);
      end
      checks++;
      if (bn !== 20) begin
         errors++; $display("FAIL basic_busy_cycles: got %0d required 20", bn);
      end
      checks++;
      if (dn !== 1 || un !== 0) begin
         errors++; $display("FAIL basic_pulse_stable: done pulses %0d unstable %0d required 1 0", dn, un);
      end
   endtask

   task automatic test_partial_mask();
      int lat, bn, dn, un;
      logic [15:0] t;
      logic d;
      run_acq(8'd30, 8'd99, 8'd31, 8'd99, 4'b0101, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (t !== 16'd30 || d !== 1'b1 || lat !== 21) begin
         errors++;
         $display("FAIL partial_mask: t_act=%0d drop_en=%b lat=%0d required 30 1 21", t, d, lat);
      end
   endtask

   task automatic test_no_sensor();
      int lat, bn, dn, un;
      logic [15:0] t;
      logic d;
      checks++;
      if (t_act === 16'd0) begin
         errors++; $display("FAIL no_sensor_precondition: t_act=%0d required nonzero", t_act);
      end
      run_acq(8'd77, 8'd88, 8'd99, 8'd11, 4'b0000, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (lat !== 5) begin
         errors++; $display("FAIL no_sensor_latency: got %0d required 5", lat);
      end
      checks++;
      if (t !== 16'd0 || d !== 1'b0) begin
         errors++; $display("FAIL no_sensor_result: t_act=%0d drop_en=%b required 0 0", t, d);
      end
      checks++;
      if (bn !== 4 || dn !== 1 || un !== 0) begin
         errors++;
         $display("FAIL no_sensor_busy: busy %0d done %0d unstable %0d required 4 1 0", bn, dn, un);
      end
   endtask

   task automatic test_extremes();
      int lat, bn, dn, un;
      logic [15:0] t;
      logic d;
      run_acq(8'd255, 8'd255, 8'd255, 8'd255, 4'b1111, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (t !== 16'd255 || d !== 1'b1) begin
         errors++; $display("FAIL max_sum: t_act=%0d drop_en=%b required 255 1", t, d);
      end
      run_acq(8'd255, 8'd255, 8'd1, 8'd200, 4'b0111, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (t !== 16'd170 || d !== 1'b1) begin
         errors++; $display("FAIL div_by_3: t_act=%0d drop_en=%b required 170 1", t, d);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bn, dn, un, exp;
      logic [15:0] t;
      logic d;
      exp = ref_avg(12, 200, 45, 3, 4'b1011);
      run_acq(8'd12, 8'd200, 8'd45, 8'd3, 4'b1011, 1'b1, lat, bn, dn, t, d, un);
      checks++;
      if (dn !== 1 || lat !== 21) begin
         errors++; $display("FAIL ignored_start: done pulses %0d lat %0d required 1 21", dn, lat);
      end
      checks++;
      if (t !== 16'(exp) || d !== 1'b1 || un !== 0) begin
         errors++;
         $display("FAIL latched_inputs: t_act=%0d drop_en=%b unstable=%0d required %0d 1 0",
                  t, d, un, exp);
      end
   endtask

   task automatic test_reset_mid_div();
      int lat, bn, dn, un, seen_done;
      logic [15:0] t;
      logic d;
      sensor1 = 8'd100; sensor2 = 8'd50; sensor3 = 8'd60; sensor4 = 8'd70;
      sensor_en = 4'b1111;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      seen_done = 0;
      for (int c = 0; c < 12; c++) begin
         if (done) seen_done++;
         @(negedge clk);
      end
      rst = 1'b1;
      #1;
      checks++;
      if (t_act !== 16'd0 || drop_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_div: t_act=%0d drop_en=%b busy=%b done=%b required 0 0 0 0",
                  t_act, drop_en, busy, done);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      rst = 1'b0;
      for (int c = 0; c < 25; c++) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      checks++;
      if (seen_done !== 0) begin
         errors++; $display("FAIL reset_no_done: done pulses %0d required 0", seen_done);
      end
      run_acq(8'd9, 8'd10, 8'd11, 8'd14, 4'b1111, 1'b0, lat, bn, dn, t, d, un);
      checks++;
      if (t !== 16'd11 || d !== 1'b1 || lat !== 21) begin
         errors++;
         $display("FAIL after_reset: t_act=%0d drop_en=%b lat=%0d required 11 1 21", t, d, lat);
      end
   endtask

   task automatic test_random();
      int lat, bn, dn, un, exp, exp_lat;
      logic [15:0] t;
      logic d;
      logic [7:0] s[4];
      logic [3:0] m;
      for (int n = 0; n < 20; n++) begin
         for (int i = 0; i < 4; i++) s[i] = 8'($urandom_range(0, 255));
         m = 4'($urandom_range(0, 15));
         exp = ref_avg(int'(s[0]), int'(s[1]), int'(s[2]), int'(s[3]), m);
         exp_lat = (m == 4'b0000) ? 5 : 21;
         run_acq(s[0], s[1], s[2], s[3], m, 1'b0, lat, bn, dn, t, d, un);
         checks++;
         if (t !== 16'(exp) || d !== (m != 4'b0000) || lat !== exp_lat || dn !== 1 || un !== 0) begin
            errors++;
            $display("FAIL random_%0d: s=%0d,%0d,%0d,%0d m=%b t_act=%0d drop_en=%b lat=%0d done=%0d unstable=%0d required t_act=%0d lat=%0d",
                     n, s[0], s[1], s[2], s[3], m, t, d, lat, dn, un, exp, exp_lat);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_partial_mask();
      test_no_sensor();
      test_extremes();
      test_back_to_back();
      test_reset_mid_div();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
